// File: rtl/alu_arb_pkg.sv
// Shared types, constants and helpers for the two-port ALU arbiter.
package alu_arb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned FN_W   = 6;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   // Operation class, carried in fn[5:4]
   localparam logic [1:0] FN_CMP   = 2'b00;
   localparam logic [1:0] FN_ARITH = 2'b01;
   localparam logic [1:0] FN_BOOL  = 2'b10;
   localparam logic [1:0] FN_SHIFT = 2'b11;

   // Compare with no predicate selected, or the unassigned shift encoding
   function automatic logic fn_illegal(input logic [FN_W-1:0] fn);
      return ((fn[5:4] == FN_CMP)   && (fn[2:1] == 2'b00)) ||
             ((fn[5:4] == FN_SHIFT) && (fn[1:0] == 2'b10));
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: compare, add/sub, bitwise and shift classes.
module alu
   import alu_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [FN_W-1:0]   fn,
   output logic [DATA_W-1:0] result
);

   logic [4:0] shamt;
   logic       cmp;
   logic       unused_fn;

   assign shamt     = b[4:0];
   assign unused_fn = fn[3];

   // Compare predicate: fn[2:1] picks eq / signed lt / unsigned lt, fn[0] inverts
   always_comb begin
      cmp = 1'b0;
      case (fn[2:1])
         2'b01:   cmp = (a == b);
         2'b10:   cmp = ($signed(a) < $signed(b));
         2'b11:   cmp = (a < b);
         default: cmp = 1'b0;
      endcase
   end

   // Result mux by operation class
   always_comb begin
      result = '0;
      unique case (fn[5:4])
         FN_CMP:   result = {31'b0, cmp ^ fn[0]};
         FN_ARITH: result = fn[0] ? (a - b) : (a + b);
         FN_BOOL: begin
            case (fn[1:0])
               2'b00:   result = a & b;
               2'b01:   result = a | b;
               2'b10:   result = a ^ b;
               default: result = ~(a | b);
            endcase
         end
         FN_SHIFT: begin
            case (fn[1:0])
               2'b00:   result = a << shamt;
               2'b01:   result = a >> shamt;
               2'b11:   result = $unsigned($signed(a) >>> shamt);
               default: result = '0;
            endcase
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the pointer flips on every granted request.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic valid0,
   input  logic valid1,
   output logic grant0,
   output logic grant1
);

   logic prio_q;

   // Grant a lone requester directly; on contention follow the pointer
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (en) begin
         if (valid0 && valid1) begin
            grant0 = ~prio_q;
            grant1 = prio_q;
         end else begin
            grant0 = valid0;
            grant1 = valid1;
         end
      end
   end

   // Pointer update; a grant always implies the handshake completes this cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else if (grant0 || grant1) begin
         prio_q <= ~prio_q;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with a registered response.
module alu_arbiter
   import alu_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [FN_W-1:0]   req0_fn,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [FN_W-1:0]   req1_fn,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              busy
);

   state_t            state;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [FN_W-1:0]   fn_q;
   logic              id_q;
   logic [DATA_W-1:0] alu_result;
   logic              grant0;
   logic              grant1;
   logic              fire;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (state == IDLE),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   // ALU sees only the holding registers, so requester changes after accept are ignored
   alu u_alu (
      .a      (a_q),
      .b      (b_q),
      .fn     (fn_q),
      .result (alu_result)
   );

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign fire       = grant0 | grant1;

   // Control FSM with registered response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         fn_q       <= '0;
         id_q       <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (fire) begin
                  a_q   <= grant1 ? req1_a  : req0_a;
                  b_q   <= grant1 ? req1_b  : req0_b;
                  fn_q  <= grant1 ? req1_fn : req0_fn;
                  id_q  <= grant1;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               resp_data  <= fn_illegal(fn_q) ? '0 : alu_result;
               resp_err   <= fn_illegal(fn_q);
               resp_id    <= id_q;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 32-bit ALU between two independent requesters. Each requester issues an operation (a, b, 6-bit fn) over a valid/ready handshake. The block grants one requester at a time using round-robin priority and executes the operation on an internal ALU instance. It returns a registered result with the requester ID and waits for response backpressure. It sits between the instruction-issue front ends and the shared ALU datapath.

## Interface
- No parameters; data width fixed at 32, fn width fixed at 6.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid&&ready.
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- req0_fn / req1_fn  in  6  ALU function code.
  - fn[5:4]: 00 compare, 01 add/sub, 10 bitwise, 11 shift.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result when resp_valid&&resp_ready.
- resp_id  out  1  requester that issued the result.
- resp_data  out  32  ALU result.
- resp_err  out  1  fn was illegal; resp_data forced to 0.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant rule.
  - If only one req*_valid is high, grant it.
  - If both are high, grant the requester selected by the priority pointer `prio` (reset 0).
  - Assert ready only to the granted requester, combinationally.
  - On the handshake: latch a, b, fn and id into holding registers, toggle `prio` to the non-granted requester, go to EXEC.
- EXEC: the ALU is driven from the holding registers only.
  - Capture the ALU output into resp_data, or 0 if illegal, and set resp_err.
  - Go to RESP.
- Illegal fn:
  - fn[5:4]=00 with fn[2:1]=00.
  - fn[5:4]=11 with fn[1:0]=10.
- RESP: resp_valid=1, with resp_data, resp_id and resp_err held stable.
  - On resp_valid&&resp_ready, go to IDLE.
- resp_data, resp_id and resp_err change only on the EXEC→RESP transition.
- `prio` toggles only on an accepted grant; a lone requester's win still toggles it.
- Requester operand changes after acceptance have no effect.

## Timing
- Reset values, applied asynchronously: state=IDLE, prio=0, all ready=0 except the combinational IDLE grant, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0.
- Latency: accept at cycle N, EXEC at N+1, resp_valid=1 at N+2.
- Back-to-back throughput: one op per 3 cycles when resp_ready is held high.
- No accept in EXEC or RESP: both ready are 0.
- Simultaneous valid: the winner is set by `prio`. The loser keeps valid high and is guaranteed the next grant.
- resp_ready low: stay in RESP indefinitely with no loss or change of the result.
- Reset mid-EXEC or mid-RESP: the pending operation is discarded, outputs return to reset values, and nothing is emitted afterward.
- Arithmetic follows the ALU: 32-bit wrap on add/sub. Compare results are zero-extended to 32 bits.

## Structure
- Package alu_arb_pkg:
  - state enum (IDLE, EXEC, RESP).
  - fn class constants FN_CMP=2'b00, FN_ARITH=2'b01, FN_BOOL=2'b10, FN_SHIFT=2'b11.
  - function fn_illegal(fn).
- Sub-module rr_arb2: two-request round-robin grant plus pointer register.
- The existing ALU module is instantiated once as u_alu.

## Test plan
- Single request: req0 with a=5, b=3, fn=6'b010000 → ready pulse. Two cycles later: resp_valid=1, resp_data=8, resp_id=0, resp_err=0.
- Contention: both valid at reset. req0 (a=5, b=3, fn=6'b010001) → resp_data=2, id=0. Then req1 is granted next (a=32'hFFFFFFFF, b=1, fn=6'b000100) → resp_data=1, id=1.
- Illegal fn: req1 with fn=6'b000000 → resp_err=1, resp_data=0. Repeat with fn=6'b110010 → resp_err=1, resp_data=0.
- Backpressure: hold resp_ready=0 for 10 cycles with req0 pending → resp fields stable, req0_ready=0 throughout. Release → IDLE, then req0 accepted.
- Reset mid-RESP: assert rst during RESP → resp_valid=0 and busy=0 immediately, prio=0, no stale response afterward.
- Fairness: both valid continuously for 8 ops → resp_id alternates 0,1,0,1…
